// File: rtl/display_scheduler_if.sv
// Number handshake between a requester and the display scheduler.
// The requester holds number/valid until ready is seen high at a clock edge.
interface display_scheduler_if;
   logic [15:0] number;
   logic        number_valid;
   logic        number_ready;
   logic        busy;

   modport master (
      output number,
      output number_valid,
      input  number_ready,
      input  busy
   );

   modport slave (
      input  number,
      input  number_valid,
      output number_ready,
      output busy
   );
endinterface

// File: rtl/display_scheduler.sv
// Binary-to-BCD converter feeding a five-digit multiplexed seven-segment
// scanner with PWM brightness and optional leading-zero blanking.
module display_scheduler #(
   parameter int SUB_DIV = 7812
) (
   input  logic                clk,
   input  logic                reset,
   display_scheduler_if.slave  req,
   input  logic [3:0]          brightness,
   input  logic                blank_lz,
   output logic [7:0]          data,
   output logic [7:0]          anode
);

   localparam int SW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

   typedef enum logic {
      IDLE,
      CONVERT
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [35:0]   sr_q;
   logic [35:0]   sr_d;
   logic [3:0]    iter_q;
   logic [3:0]    iter_d;
   logic [19:0]   digits_q;
   logic [19:0]   digits_d;

   logic [SW-1:0] sub_q;
   logic [3:0]    phase_q;
   logic [2:0]    slot_q;
   logic          sub_wrap;

   logic [3:0]    cur_digit;
   logic [4:0]    zero;
   logic [4:0]    blank;
   logic          lit;
   logic [7:0]    seg;

   // One double-dabble step: correct BCD nibbles >= 5, then shift left.
   function automatic logic [35:0] dd_step(input logic [35:0] v);
      logic [35:0] a;
      a = v;
      for (int i = 0; i < 5; i++) begin
         if (a[16+4*i +: 4] >= 4'd5)
            a[16+4*i +: 4] = a[16+4*i +: 4] + 4'd3;
      end
      return {a[34:0], 1'b0};
   endfunction

   assign req.number_ready = (state_q == IDLE) && reset;
   assign req.busy         = (state_q == CONVERT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         iter_q   <= '0;
         digits_q <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         iter_q   <= iter_d;
         digits_q <= digits_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      iter_d   = iter_q;
      digits_d = digits_q;
      unique case (state_q)
         IDLE: begin
            if (req.number_valid) begin
               sr_d    = {20'b0, req.number};
               iter_d  = '0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            sr_d   = dd_step(sr_q);
            iter_d = iter_q + 4'd1;
            if (iter_q == 4'd15) begin
               digits_d = sr_d[35:16];
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sub_wrap = (sub_q == SW'(SUB_DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sub_q   <= '0;
         phase_q <= '0;
         slot_q  <= '0;
      end else if (sub_wrap) begin
         sub_q   <= '0;
         phase_q <= phase_q + 4'd1;
         if (phase_q == 4'd15)
            slot_q <= (slot_q == 3'd4) ? 3'd0 : slot_q + 3'd1;
      end else begin
         sub_q <= sub_q + 1'b1;
      end
   end

   always_comb begin
      cur_digit = digits_q[3:0];
      unique case (slot_q)
         3'd1:    cur_digit = digits_q[7:4];
         3'd2:    cur_digit = digits_q[11:8];
         3'd3:    cur_digit = digits_q[15:12];
         3'd4:    cur_digit = digits_q[19:16];
         default: cur_digit = digits_q[3:0];
      endcase
   end

   // A digit is blank only if it and every more significant digit are zero.
   always_comb begin
      for (int i = 0; i < 5; i++)
         zero[i] = (digits_q[4*i +: 4] == 4'd0);
      blank    = '0;
      blank[4] = blank_lz && zero[4];
      blank[3] = blank[4] && zero[3];
      blank[2] = blank[3] && zero[2];
      blank[1] = blank[2] && zero[1];
   end

   assign lit = (phase_q <= brightness) && !blank[slot_q];

   always_comb begin
      seg = 8'h80;
      case (cur_digit)
         4'd0:    seg = 8'h81;
         4'd1:    seg = 8'hCF;
         4'd2:    seg = 8'h92;
         4'd3:    seg = 8'h86;
         4'd4:    seg = 8'hCC;
         4'd5:    seg = 8'hA4;
         4'd6:    seg = 8'hA0;
         4'd7:    seg = 8'h8F;
         4'd8:    seg = 8'h80;
         4'd9:    seg = 8'h84;
         default: seg = 8'h80;
      endcase
   end

   // Registered drive keeps the pins glitch-free and forces FF in reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         anode <= 8'hFF;
         data  <= 8'hFF;
      end else begin
         anode <= lit ? ~(8'd1 << slot_q) : 8'hFF;
         data  <= lit ? seg : 8'hFF;
      end
   end

endmodule
